// File: rtl/native2wb.sv
// Native user port to classic Wishbone B4 master bridge, one transaction outstanding.
// Optional ack watchdog is compiled in when NATIVE2WB_TIMEOUT_EN is defined.
module native2wb #(
   parameter int                ADDR_W         = 32,
   parameter int                DATA_W         = 256,
   parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'h0200_0000,
   parameter int                TIMEOUT_CYCLES = 1024
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_payload_we,
   input  logic [ADDR_W-1:0]   cmd_payload_addr,
   input  logic                wdata_valid,
   output logic                wdata_ready,
   input  logic [DATA_W-1:0]   wdata_payload_data,
   input  logic [DATA_W/8-1:0] wdata_payload_we,
   output logic                rdata_valid,
   input  logic                rdata_ready,
   output logic [DATA_W-1:0]   rdata_payload_data,
   output logic [ADDR_W-1:0]   wishbone_adr,
   output logic [DATA_W-1:0]   wishbone_dat_w,
   input  logic [DATA_W-1:0]   wishbone_dat_r,
   output logic [DATA_W/8-1:0] wishbone_sel,
   output logic                wishbone_cyc,
   output logic                wishbone_stb,
   output logic                wishbone_we,
   output logic [2:0]          wishbone_cti,
   output logic [1:0]          wishbone_bte,
   input  logic                wishbone_ack,
   input  logic                wishbone_err,
   output logic                bus_error
);

   typedef enum logic [1:0] {IDLE, WDATA, BUS, RRESP} state_t;

   state_t state, state_nxt;
   logic   timeout, term_err, term;

`ifdef NATIVE2WB_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TO_W-1:0] to_cnt;

   // Counter idles at zero outside BUS, so every BUS entry starts a fresh count.
   always_ff @(posedge sys_clk) begin
      if (sys_rst || state != BUS) to_cnt <= '0;
      else                         to_cnt <= to_cnt + 1'b1;
   end

   assign timeout = (state == BUS) && !wishbone_ack && !wishbone_err &&
                    (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   assign term_err     = wishbone_err | timeout;
   assign term         = wishbone_ack | term_err;
   assign wishbone_cti = 3'b000;
   assign wishbone_bte = 2'b00;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cmd_valid)   state_nxt = cmd_payload_we ? WDATA : BUS;
         WDATA:   if (wdata_valid) state_nxt = BUS;
         BUS:     if (term)        state_nxt = wishbone_we ? IDLE : RRESP;
         RRESP:   if (rdata_ready) state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready   = 1'b0;
      wdata_ready = 1'b0;
      rdata_valid = 1'b0;
      case (state)
         IDLE:    cmd_ready   = 1'b1;
         WDATA:   wdata_ready = 1'b1;
         RRESP:   rdata_valid = 1'b1;
         default: ;
      endcase
   end

   // cyc/stb follow the next state so they rise with BUS entry and drop on the termination edge.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wishbone_cyc       <= 1'b0;
         wishbone_stb       <= 1'b0;
         wishbone_we        <= 1'b0;
         wishbone_adr       <= '0;
         wishbone_dat_w     <= '0;
         wishbone_sel       <= '0;
         rdata_payload_data <= '0;
         bus_error          <= 1'b0;
      end else begin
         wishbone_cyc <= (state_nxt == BUS);
         wishbone_stb <= (state_nxt == BUS);
         bus_error    <= (state == BUS) && term_err;
         if (state == IDLE && cmd_valid) begin
            wishbone_adr <= cmd_payload_addr + BASE_ADDR;
            wishbone_we  <= cmd_payload_we;
            if (!cmd_payload_we) wishbone_sel <= '1;
         end
         if (state == WDATA && wdata_valid) begin
            wishbone_dat_w <= wdata_payload_data;
            wishbone_sel   <= wdata_payload_we;
         end
         if (state == BUS && term && !wishbone_we)
            rdata_payload_data <= term_err ? '0 : wishbone_dat_r;
      end
   end

endmodule

// File: tb/tb_native2wb.sv
// Directed bench for native2wb: read, write, backpressure, error, reset-in-BUS, optional timeout.
module tb_native2wb;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 256;
   localparam int SEL_W  = DATA_W / 8;

   logic              sys_clk = 1'b0;
   logic              sys_rst = 1'b1;
   logic              cmd_valid = 1'b0, cmd_ready, cmd_payload_we = 1'b0;
   logic [ADDR_W-1:0] cmd_payload_addr = '0;
   logic              wdata_valid = 1'b0, wdata_ready;
   logic [DATA_W-1:0] wdata_payload_data = '0;
   logic [SEL_W-1:0]  wdata_payload_we = '0;
   logic              rdata_valid, rdata_ready = 1'b0;
   logic [DATA_W-1:0] rdata_payload_data;
   logic [ADDR_W-1:0] wishbone_adr;
   logic [DATA_W-1:0] wishbone_dat_w, wishbone_dat_r = '0;
   logic [SEL_W-1:0]  wishbone_sel;
   logic              wishbone_cyc, wishbone_stb, wishbone_we;
   logic [2:0]        wishbone_cti;
   logic [1:0]        wishbone_bte;
   logic              wishbone_ack = 1'b0, wishbone_err = 1'b0;
   logic              bus_error;

   int checks = 0;
   int errors = 0;

   localparam logic [DATA_W-1:0] A5   = {8{32'hA5A5_A5A5}};
   localparam logic [DATA_W-1:0] ONES = '1;

   native2wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(32'h0200_0000), .TIMEOUT_CYCLES(16)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_payload_we(cmd_payload_we),
      .cmd_payload_addr(cmd_payload_addr),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
      .wdata_payload_data(wdata_payload_data), .wdata_payload_we(wdata_payload_we),
      .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata_payload_data(rdata_payload_data),
      .wishbone_adr(wishbone_adr), .wishbone_dat_w(wishbone_dat_w), .wishbone_dat_r(wishbone_dat_r),
      .wishbone_sel(wishbone_sel), .wishbone_cyc(wishbone_cyc), .wishbone_stb(wishbone_stb),
      .wishbone_we(wishbone_we), .wishbone_cti(wishbone_cti), .wishbone_bte(wishbone_bte),
      .wishbone_ack(wishbone_ack), .wishbone_err(wishbone_err), .bus_error(bus_error)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic nclk(input int n = 1);
      repeat (n) @(negedge sys_clk);
   endtask

   // Issue a read command at the current negedge; returns at the negedge of the first BUS cycle.
   task automatic issue_read(input logic [ADDR_W-1:0] a);
      cmd_valid = 1'b1; cmd_payload_we = 1'b0; cmd_payload_addr = a;
      nclk();
      cmd_valid = 1'b0;
   endtask

   initial begin
      int n;
      nclk(2);
      sys_rst = 1'b0;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_cyc", {wishbone_cyc, wishbone_stb, wishbone_we}, 0);
      chk("rst_valids", {wdata_ready, rdata_valid, bus_error}, 0);
      chk("rst_adr", wishbone_adr, 0);
      chk("rst_cti_bte", {wishbone_cti, wishbone_bte}, 0);

      // Read, ack two cycles after stb
      issue_read(32'h10);
      chk("rd_cyc", {wishbone_cyc, wishbone_stb, wishbone_we}, 3'b110);
      chk("rd_adr", wishbone_adr, 32'h0200_0010);
      chk("rd_sel", wishbone_sel, ONES[SEL_W-1:0]);
      chk("rd_cmd_ready", cmd_ready, 0);
      nclk();
      chk("rd_hold", {wishbone_cyc, rdata_valid}, 2'b10);
      nclk();
      wishbone_ack = 1'b1; wishbone_dat_r = A5;
      nclk();
      wishbone_ack = 1'b0; wishbone_dat_r = '0;
      chk("rd_valid", {rdata_valid, wishbone_cyc, bus_error}, 3'b100);
      chk("rd_data", rdata_payload_data, A5);
      rdata_ready = 1'b1;
      nclk();
      rdata_ready = 1'b0;
      chk("rd_done", {rdata_valid, cmd_ready}, 2'b01);

      // wdata_valid outside WDATA is ignored
      wdata_valid = 1'b1; wdata_payload_data = ONES; wdata_payload_we = '1;
      nclk();
      wdata_valid = 1'b0;
      chk("idle_wdata_ign", {wdata_ready, wishbone_cyc, cmd_ready}, 3'b001);

      // Write with wdata delayed 3 cycles
      cmd_valid = 1'b1; cmd_payload_we = 1'b1; cmd_payload_addr = 32'h4;
      nclk();
      cmd_valid = 1'b0; cmd_payload_we = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("wr_wait", {wdata_ready, wishbone_cyc, cmd_ready}, 3'b100);
         if (i < 2) nclk();
      end
      wdata_valid = 1'b1; wdata_payload_data = DATA_W'(32'hDEAD_BEEF); wdata_payload_we = 32'h0000_000F;
      nclk();
      wdata_valid = 1'b0;
      chk("wr_cyc", {wishbone_cyc, wishbone_stb, wishbone_we, wdata_ready}, 4'b1110);
      chk("wr_adr", wishbone_adr, 32'h0200_0004);
      chk("wr_dat", wishbone_dat_w, DATA_W'(32'hDEAD_BEEF));
      chk("wr_sel", wishbone_sel, 32'h0000_000F);
      wishbone_ack = 1'b1;
      nclk();
      wishbone_ack = 1'b0;
      chk("wr_done", {wishbone_cyc, cmd_ready, rdata_valid, bus_error}, 4'b0100);

      // Read with backpressure, next command held pending
      issue_read(32'h20);
      wishbone_ack = 1'b1; wishbone_dat_r = DATA_W'(32'h1234_5678);
      nclk();
      wishbone_ack = 1'b0; wishbone_dat_r = '0;
      cmd_valid = 1'b1; cmd_payload_addr = 32'h30;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold", {rdata_valid, cmd_ready, wishbone_cyc}, 3'b100);
         chk("bp_data", rdata_payload_data, DATA_W'(32'h1234_5678));
         nclk();
      end
      rdata_ready = 1'b1;
      nclk();
      rdata_ready = 1'b0;
      chk("bp_after", {rdata_valid, cmd_ready}, 2'b01);
      nclk();
      cmd_valid = 1'b0;
      chk("bp_next_adr", wishbone_adr, 32'h0200_0030);
      chk("bp_next_cyc", wishbone_cyc, 1);
      wishbone_ack = 1'b1; wishbone_dat_r = DATA_W'(8'h55);
      nclk();
      wishbone_ack = 1'b0;
      chk("bp_next_data", rdata_payload_data, DATA_W'(8'h55));
      rdata_ready = 1'b1;
      nclk();
      rdata_ready = 1'b0;

      // ack and err together: err wins
      issue_read(32'h40);
      wishbone_ack = 1'b1; wishbone_err = 1'b1; wishbone_dat_r = ONES;
      nclk();
      wishbone_ack = 1'b0; wishbone_err = 1'b0; wishbone_dat_r = '0;
      chk("err_flags", {rdata_valid, bus_error, wishbone_cyc}, 3'b110);
      chk("err_data", rdata_payload_data, 0);
      rdata_ready = 1'b1;
      nclk();
      rdata_ready = 1'b0;
      chk("err_end", {bus_error, cmd_ready, rdata_valid}, 3'b010);

      // Reset while stb active
      issue_read(32'h50);
      chk("rb_stb", wishbone_stb, 1);
      sys_rst = 1'b1;
      nclk();
      sys_rst = 1'b0;
      chk("rb_drop", {wishbone_cyc, wishbone_stb, rdata_valid, cmd_ready}, 4'b0001);
      nclk(2);
      chk("rb_quiet", {rdata_valid, wishbone_cyc, bus_error}, 0);
      issue_read(32'h60);
      chk("rb_next_adr", wishbone_adr, 32'h0200_0060);
      wishbone_ack = 1'b1; wishbone_dat_r = DATA_W'(8'h77);
      nclk();
      wishbone_ack = 1'b0; wishbone_dat_r = '0;
      chk("rb_next_data", {rdata_valid, rdata_payload_data}, {1'b1, DATA_W'(8'h77)});
      rdata_ready = 1'b1;
      nclk();
      rdata_ready = 1'b0;

`ifdef NATIVE2WB_TIMEOUT_EN
      // Slave never responds; watchdog terminates after 16 BUS cycles
      wishbone_dat_r = ONES;
      issue_read(32'h70);
      n = 0;
      while (wishbone_cyc && n < 40) begin
         n++;
         nclk();
      end
      chk("to_len", n, 16);
      chk("to_flags", {rdata_valid, bus_error}, 2'b11);
      chk("to_data", rdata_payload_data, 0);
      wishbone_dat_r = '0;
      rdata_ready = 1'b1;
      nclk();
      rdata_ready = 1'b0;
      chk("to_end", {bus_error, cmd_ready}, 2'b01);
`else
      n = 0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
